// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//
// Read-side adapter placed directly downstream of fifo_ctrl and its register
// file. It turns the FIFO pop interface (rd/empty) into a valid/ready stream
// master. A 2-entry skid buffer sustains one word per cycle with no
// combinational path from m_ready_i to the FIFO read strobe.
//
// Ports:
//   clk_i      clock, rising-edge
//   rst_i      asynchronous active-high reset
//   empty_i    FIFO empty flag (fifo_ctrl.empty_o)
//   rd_data_i  register-file word at the current read address (combinational)
//   rd_o       FIFO pop strobe (to fifo_ctrl.rd_i)
//   flush_i    synchronous discard of the skid buffer contents
//   m_data_o   stream data (head entry)
//   m_valid_o  stream valid
//   m_ready_i  stream ready from the consumer
//   count_o    skid buffer occupancy 0..2; also exposes the FSM state
//
// Handshake: a beat transfers on a rising edge where m_valid_o and m_ready_i
// are both high (and flush_i is low). Once m_valid_o is high, m_valid_o and
// m_data_o hold until the beat transfers, unless the buffer is flushed or
// reset. m_valid_o never depends on m_ready_i.
module fifo_rd_stream #(
    parameter int DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 empty_i,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 rd_o,
    input  logic                 flush_i,
    output logic [DataWidth-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [1:0]           count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DataWidth-1:0] slot0;
    logic [DataWidth-1:0] slot1;
    logic [DataWidth-1:0] slot0_next;
    logic [DataWidth-1:0] slot1_next;
    logic                 push;
    logic                 pop;

    // The strobe looks only at registered occupancy, never at m_ready_i, so
    // the FIFO read path stays free of the consumer's timing. Gating with
    // rst_i keeps the strobe low during the asynchronous reset window.
    assign rd_o = ~rst_i & ~empty_i & ~flush_i & (state != TWO);

    // A word is captured on the same edge that advances the FIFO pointer.
    assign push = rd_o;
    assign pop  = m_valid_o & m_ready_i & ~flush_i;

    assign m_valid_o = (state != EMPTY);
    assign m_data_o  = slot0;
    assign count_o   = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            state <= state_next;
            slot0 <= slot0_next;
            slot1 <= slot1_next;
        end
    end

    always_comb begin
        state_next = state;
        slot0_next = slot0;
        slot1_next = slot1;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    slot0_next = rd_data_i;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_next = TWO;
                    slot1_next = rd_data_i;
                end else if (push && pop) begin
                    // Head leaves and the new word takes its place.
                    slot0_next = rd_data_i;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // rd_o is low in TWO, so only a pop can happen here.
                if (pop) begin
                    state_next = ONE;
                    slot0_next = slot1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        // Slot contents are left as they are; an empty buffer ignores them.
        if (flush_i) begin
            state_next = EMPTY;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         empty;
    logic [W-1:0] rd_data;
    logic         rd;
    logic         flush;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [1:0]   count;

    // FIFO contents (head at index 0) and the words popped from the FIFO
    // but not yet delivered on the stream, in order.
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rd_pulses = 0;

    fifo_rd_stream #(.DataWidth(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .empty_i   (empty),
        .rd_data_i (rd_data),
        .rd_o      (rd),
        .flush_i   (flush),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .count_o   (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model and driver tasks ----------------
    function automatic void update_fifo_if();
        empty   = (fifo_q.size() == 0);
        rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        update_fifo_if();
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Sampled at the rising edge before any DUT state update; inputs are
    // only changed near the falling edge.
    initial begin : monitor
        logic         s_rd, s_empty, s_valid, s_ready, s_flush, s_rst;
        logic [W-1:0] s_data;
        logic [1:0]   s_count;
        logic         stalled;
        logic [W-1:0] stall_data;
        logic [W-1:0] exp_w;
        stalled = 1'b0;
        stall_data = '0;
        forever begin
            @(posedge clk);
            s_rd = rd; s_empty = empty; s_valid = m_valid; s_ready = m_ready;
            s_flush = flush; s_rst = rst; s_data = m_data; s_count = count;
            if (s_rst) begin
                exp_q.delete();
                stalled = 1'b0;
            end else begin
                total_cnt++;
                if (s_rd && s_empty) $display("FAIL rd_on_empty rd=%0b empty=%0b exp rd=0", s_rd, s_empty);
                else pass_cnt++;

                total_cnt++;
                if (s_count !== 2'(exp_q.size()))
                    $display("FAIL occupancy got %0d exp %0d", s_count, exp_q.size());
                else pass_cnt++;

                total_cnt++;
                if (s_valid !== (exp_q.size() != 0))
                    $display("FAIL valid got %0b exp %0b", s_valid, exp_q.size() != 0);
                else pass_cnt++;

                if (stalled) begin
                    total_cnt++;
                    if (s_valid !== 1'b1 || s_data !== stall_data)
                        $display("FAIL stall_stable got v=%0b d=%h exp v=1 d=%h", s_valid, s_data, stall_data);
                    else pass_cnt++;
                end
                stalled = s_valid && !s_ready && !s_flush;
                stall_data = s_data;

                if (s_flush) begin
                    exp_q.delete();
                end else if (s_valid && s_ready) begin
                    exp_w = (exp_q.size() != 0) ? exp_q[0] : '0;
                    total_cnt++;
                    if (exp_q.size() == 0 || s_data !== exp_w)
                        $display("FAIL beat_data got %h exp %h (pending %0d)", s_data, exp_w, exp_q.size());
                    else pass_cnt++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (s_rd) begin
                    rd_pulses++;
                    if (fifo_q.size() != 0) begin
                        exp_q.push_back(fifo_q[0]);
                        void'(fifo_q.pop_front());
                    end
                end
            end
            #1 update_fifo_if();
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        total_cnt++;
        if (m_valid !== 1'b0 || count !== 2'd0 || rd !== 1'b0 || m_data !== '0)
            $display("FAIL reset_values got v=%0b c=%0d rd=%0b d=%h exp 0", m_valid, count, rd, m_data);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0 || count !== 2'd0 || rd !== 1'b0)
            $display("FAIL post_reset_idle got v=%0b c=%0d rd=%0b exp 0", m_valid, count, rd);
        else pass_cnt++;
    endtask

    task automatic test_single();
        @(negedge clk);
        m_ready = 1'b1;
        push_word(8'hA5);
        #1;
        total_cnt++;
        if (rd !== 1'b1) $display("FAIL single_rd got %0b exp 1", rd);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || rd !== 1'b0)
            $display("FAIL single_beat got v=%0b d=%h rd=%0b exp v=1 d=a5 rd=0", m_valid, m_data, rd);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0 || count !== 2'd0)
            $display("FAIL single_idle got v=%0b c=%0d exp 0", m_valid, count);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fifo_q.push_back(W'(i));
        update_fifo_if();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== W'(i) || count !== 2'd1)
                $display("FAIL stream_%0d got v=%0b d=%h c=%0d exp v=1 d=%h c=1", i, m_valid, m_data, count, W'(i));
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL stream_end got v=%0b exp 0", m_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words [4];
        int           start;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        @(negedge clk);
        m_ready = 1'b0;
        start = rd_pulses;
        for (int i = 0; i < 4; i++) fifo_q.push_back(words[i]);
        update_fifo_if();
        repeat (5) @(negedge clk);
        total_cnt++;
        if (rd_pulses - start !== 2 || count !== 2'd2 || m_data !== 8'h11)
            $display("FAIL bp_hold got pulses=%0d c=%0d d=%h exp pulses=2 c=2 d=11", rd_pulses - start, count, m_data);
        else pass_cnt++;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== words[i])
                $display("FAIL bp_release_%0d got v=%0b d=%h exp v=1 d=%h", i, m_valid, m_data, words[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (m_valid !== 1'b0 || count !== 2'd0)
            $display("FAIL bp_drained got v=%0b c=%0d exp 0", m_valid, count);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        m_ready = 1'b0;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (count !== 2'd2 || m_data !== 8'h11 || fifo_q.size() != 1)
            $display("FAIL flush_setup got c=%0d d=%h fifo=%0d exp c=2 d=11 fifo=1", count, m_data, fifo_q.size());
        else pass_cnt++;
        m_ready = 1'b1;
        flush = 1'b1;
        #1;
        total_cnt++;
        if (rd !== 1'b0) $display("FAIL flush_rd got %0b exp 0", rd);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        total_cnt++;
        if (count !== 2'd0 || m_valid !== 1'b0)
            $display("FAIL flush_empty got c=%0d v=%0b exp 0", count, m_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 8'h33)
            $display("FAIL flush_next got v=%0b d=%h exp v=1 d=33", m_valid, m_data);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(W'($urandom_range(1, 255)));
        repeat (3) @(negedge clk);
        total_cnt++;
        if (count !== 2'd2) $display("FAIL rstmid_setup got c=%0d exp 2", count);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (m_valid !== 1'b0 || count !== 2'd0 || rd !== 1'b0 || m_data !== '0)
            $display("FAIL rstmid_async got v=%0b c=%0d rd=%0b d=%h exp 0", m_valid, count, rd, m_data);
        else pass_cnt++;
        fifo_q.delete();
        update_fifo_if();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0 || count !== 2'd0 || rd !== 1'b0)
            $display("FAIL rstmid_idle got v=%0b c=%0d rd=%0b exp 0", m_valid, count, rd);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int guard;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 39) == 0);
            if (fifo_q.size() < 16 && $urandom_range(0, 2) != 0)
                push_word(W'($urandom_range(0, 255)));
        end
        @(negedge clk);
        m_ready = 1'b1;
        flush = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total_cnt++;
        if (exp_q.size() != 0 || fifo_q.size() != 0)
            $display("FAIL random_drain got pending=%0d fifo=%0d exp 0", exp_q.size(), fifo_q.size());
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        update_fifo_if();
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
